// File: rtl/axis_packetizer.sv
// AXI-Stream packetizer: one-word hold stage (H) feeding a registered output stage (O), with tlast
// inserted on a beat count or an idle timeout. Define AXIS_PKTZR_STAT_EN to enable the pkt_count statistic.
module axis_packetizer #(
    parameter int DATA_WD = 64,
    parameter int CNT_WD  = 16,
    parameter int TMO_WD  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_axis_tvalid,
    input  logic [DATA_WD-1:0] s_axis_tdata,
    output logic               s_axis_tready,
    output logic               m_axis_tvalid,
    output logic [DATA_WD-1:0] m_axis_tdata,
    output logic               m_axis_tlast,
    input  logic               m_axis_tready,
    input  logic [CNT_WD-1:0]  cfg_pkt_len,
    input  logic [TMO_WD-1:0]  cfg_timeout,
    output logic               busy,
    output logic [CNT_WD-1:0]  pkt_count
);

    logic               hvalid;
    logic [DATA_WD-1:0] hdata;
    logic [CNT_WD-1:0]  beat_cnt;
    logic [TMO_WD-1:0]  idle_cnt;

    logic o_free;
    logic s_hs;
    logic close_cnt;
    logic close_tmo;
    logic close_any;
    logic move;

    assign o_free        = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = !rst && (!hvalid || o_free);
    assign s_hs          = s_axis_tvalid && s_axis_tready;

    // beat_cnt counts beats already sent in this packet, so the held beat is beat_cnt + 1.
    assign close_cnt = (cfg_pkt_len != '0) && ((beat_cnt + CNT_WD'(1)) == cfg_pkt_len);
    assign close_tmo = (cfg_timeout != '0) && (idle_cnt >= cfg_timeout);
    assign close_any = close_cnt || close_tmo;
    assign move      = hvalid && o_free && (s_axis_tvalid || close_any);

    assign busy = hvalid || m_axis_tvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (o_free) begin
            m_axis_tvalid <= move;
            if (move) begin
                m_axis_tdata <= hdata;
                m_axis_tlast <= close_any;
            end
        end
    end

    // A full H only accepts a new beat in the cycle it empties into O, so nothing is overwritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            hvalid <= 1'b0;
            hdata  <= '0;
        end else if (s_hs) begin
            hvalid <= 1'b1;
            hdata  <= s_axis_tdata;
        end else if (move) begin
            hvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (move) begin
            beat_cnt <= close_any ? '0 : beat_cnt + CNT_WD'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (s_hs) begin
            idle_cnt <= '0;
        end else if (hvalid && (idle_cnt != '1)) begin
            idle_cnt <= idle_cnt + TMO_WD'(1);
        end
    end

`ifdef AXIS_PKTZR_STAT_EN
    logic [CNT_WD-1:0] pkt_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_q <= '0;
        end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            pkt_cnt_q <= pkt_cnt_q + CNT_WD'(1);
        end
    end

    assign pkt_count = pkt_cnt_q;
`else
    assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_axis_packetizer.sv
// Self-checking bench for axis_packetizer: cycle-vector table for the count and timeout closes,
// then directed sequences for back-pressure, close/input collision, mid-packet reset and pkt_count.
module tb_axis_packetizer;

    localparam int DW = 64;
    localparam int CW = 16;
    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_axis_tvalid;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tready;
    logic          m_axis_tvalid;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tlast;
    logic          m_axis_tready;
    logic [CW-1:0] cfg_pkt_len;
    logic [TW-1:0] cfg_timeout;
    logic          busy;
    logic [CW-1:0] pkt_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axis_packetizer #(.DATA_WD(DW), .CNT_WD(CW), .TMO_WD(TW)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tready (s_axis_tready),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .cfg_pkt_len   (cfg_pkt_len),
        .cfg_timeout   (cfg_timeout),
        .busy          (busy),
        .pkt_count     (pkt_count)
    );

    typedef struct {
        logic [CW-1:0] len;
        logic [TW-1:0] tmo;
        logic          s_valid;
        logic [DW-1:0] s_data;
        logic          m_ready;
        logic          e_sready;
        logic          e_mvalid;
        logic [DW-1:0] e_mdata;
        logic          e_mlast;
        logic          e_busy;
    } vec_t;

    vec_t          vt[$];
    logic [DW-1:0] exp_d[$];
    logic          exp_l[$];

    function automatic vec_t mk(input int len, input int tmo, input logic sv, input int sd,
                                input logic er, input logic ev, input int ed, input logic el,
                                input logic eb);
        vec_t v;
        v.len      = CW'(len);
        v.tmo      = TW'(tmo);
        v.s_valid  = sv;
        v.s_data   = DW'(sd);
        v.m_ready  = 1'b1;
        v.e_sready = er;
        v.e_mvalid = ev;
        v.e_mdata  = DW'(ed);
        v.e_mlast  = el;
        v.e_busy   = eb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc_drive(input logic sv, input logic [DW-1:0] sd, input logic mr);
        @(negedge clk);
        s_axis_tvalid = sv;
        s_axis_tdata  = sd;
        m_axis_tready = mr;
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst           = 1'b1;
        s_axis_tvalid = 1'b0;
        #1;
        chk("rst s_tready", 64'(s_axis_tready), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst m_tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("rst busy", 64'(busy), 64'(0));
        chk("rst m_tdata", m_axis_tdata, 64'(0));
        chk("rst m_tlast", 64'(m_axis_tlast), 64'(0));
    endtask

    // Streams n words base, base+1, ... and compares the output beats against exp_d/exp_l.
    task automatic run_stream(input string tag, input int n, input logic [DW-1:0] base,
                              input bit alt, input int budget);
        int            sent;
        int            got;
        int            extra;
        logic          stall;
        logic [DW-1:0] sd;
        logic          sl;
        sent  = 0;
        got   = 0;
        extra = 0;
        stall = 1'b0;
        sd    = '0;
        sl    = 1'b0;
        for (int c = 0; c < budget && got < exp_d.size(); c++) begin
            @(negedge clk);
            m_axis_tready = alt ? (c % 2 == 0) : 1'b1;
            s_axis_tvalid = (sent < n);
            s_axis_tdata  = (sent < n) ? base + DW'(sent) : '0;
            #1;
            if (stall) begin
                chk({tag, " stall valid"}, 64'(m_axis_tvalid), 64'(1));
                chk({tag, " stall data"}, m_axis_tdata, sd);
                chk({tag, " stall last"}, 64'(m_axis_tlast), 64'(sl));
            end
            stall = m_axis_tvalid && !m_axis_tready;
            sd    = m_axis_tdata;
            sl    = m_axis_tlast;
            if (m_axis_tvalid && m_axis_tready) begin
                chk($sformatf("%s beat%0d data", tag, got), m_axis_tdata, exp_d[got]);
                chk($sformatf("%s beat%0d last", tag, got), 64'(m_axis_tlast), 64'(exp_l[got]));
                got++;
            end
            if (s_axis_tvalid && s_axis_tready) sent++;
        end
        chk({tag, " beats out"}, 64'(got), 64'(exp_d.size()));
        chk({tag, " words in"}, 64'(sent), 64'(n));
        for (int c = 0; c < 12; c++) begin
            cyc_drive(1'b0, '0, 1'b1);
            if (m_axis_tvalid) extra++;
        end
        chk({tag, " extra beats"}, 64'(extra), 64'(0));
        chk({tag, " idle busy"}, 64'(busy), 64'(0));
    endtask

    task automatic set_exp(input int n, input int base, input int len);
        exp_d.delete();
        exp_l.delete();
        for (int i = 0; i < n; i++) begin
            exp_d.push_back(DW'(base + i));
            exp_l.push_back(((i + 1) % len) == 0);
        end
    endtask

    initial begin
        int   found;
        logic [CW-1:0] exp_pkts;

        rst           = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b0;
        cfg_pkt_len   = '0;
        cfg_timeout   = '0;

        // len=4, tmo=0, words 1..8 back-to-back: one beat per cycle, tlast on 4 and 8.
        vt.push_back(mk(4, 0, 1, 1, 1, 0, 0, 0, 0));
        vt.push_back(mk(4, 0, 1, 2, 1, 0, 0, 0, 1));
        vt.push_back(mk(4, 0, 1, 3, 1, 1, 1, 0, 1));
        vt.push_back(mk(4, 0, 1, 4, 1, 1, 2, 0, 1));
        vt.push_back(mk(4, 0, 1, 5, 1, 1, 3, 0, 1));
        vt.push_back(mk(4, 0, 1, 6, 1, 1, 4, 1, 1));
        vt.push_back(mk(4, 0, 1, 7, 1, 1, 5, 0, 1));
        vt.push_back(mk(4, 0, 1, 8, 1, 1, 6, 0, 1));
        vt.push_back(mk(4, 0, 0, 0, 1, 1, 7, 0, 1));
        vt.push_back(mk(4, 0, 0, 0, 1, 1, 8, 1, 1));
        vt.push_back(mk(4, 0, 0, 0, 1, 0, 0, 0, 0));
        // len=0, tmo=5, words 1,2,3 then idle: 3 leaves with tlast after 5 idle cycles.
        vt.push_back(mk(0, 5, 1, 1, 1, 0, 0, 0, 0));
        vt.push_back(mk(0, 5, 1, 2, 1, 0, 0, 0, 1));
        vt.push_back(mk(0, 5, 1, 3, 1, 1, 1, 0, 1));
        vt.push_back(mk(0, 5, 0, 0, 1, 1, 2, 0, 1));
        vt.push_back(mk(0, 5, 0, 0, 1, 0, 0, 0, 1));
        vt.push_back(mk(0, 5, 0, 0, 1, 0, 0, 0, 1));
        vt.push_back(mk(0, 5, 0, 0, 1, 0, 0, 0, 1));
        vt.push_back(mk(0, 5, 0, 0, 1, 0, 0, 0, 1));
        vt.push_back(mk(0, 5, 0, 0, 1, 0, 0, 0, 1));
        vt.push_back(mk(0, 5, 0, 0, 1, 1, 3, 1, 1));
        vt.push_back(mk(0, 5, 0, 0, 1, 0, 0, 0, 0));

        repeat (3) @(negedge clk);
        #1;
        chk("reset s_tready", 64'(s_axis_tready), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset m_tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("reset m_tdata", m_axis_tdata, 64'(0));
        chk("reset m_tlast", 64'(m_axis_tlast), 64'(0));
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset pkt_count", 64'(pkt_count), 64'(0));

        for (int i = 0; i < vt.size(); i++) begin
            cfg_pkt_len = vt[i].len;
            cfg_timeout = vt[i].tmo;
            cyc_drive(vt[i].s_valid, vt[i].s_data, vt[i].m_ready);
            chk($sformatf("vec%0d s_tready", i), 64'(s_axis_tready), 64'(vt[i].e_sready));
            chk($sformatf("vec%0d m_tvalid", i), 64'(m_axis_tvalid), 64'(vt[i].e_mvalid));
            chk($sformatf("vec%0d busy", i), 64'(busy), 64'(vt[i].e_busy));
            if (vt[i].e_mvalid) begin
                chk($sformatf("vec%0d m_tdata", i), m_axis_tdata, vt[i].e_mdata);
                chk($sformatf("vec%0d m_tlast", i), 64'(m_axis_tlast), 64'(vt[i].e_mlast));
            end
        end

        // len=3, alternating downstream ready: every word once, stable while stalled.
        cfg_pkt_len = CW'(3);
        cfg_timeout = '0;
        set_exp(6, 1, 3);
        run_stream("stall", 6, DW'(1), 1'b1, 200);

        // len=0, tmo=4: B arrives in the very cycle the timeout closes A.
        cfg_pkt_len = '0;
        cfg_timeout = TW'(4);
        cyc_drive(1'b1, DW'('hA), 1'b1);
        chk("coll A accept", 64'(s_axis_tready), 64'(1));
        for (int k = 0; k < 4; k++) begin
            cyc_drive(1'b0, '0, 1'b1);
            chk($sformatf("coll early%0d", k), 64'(m_axis_tvalid), 64'(0));
        end
        cyc_drive(1'b1, DW'('hB), 1'b1);
        chk("coll B m_tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("coll B accept", 64'(s_axis_tready), 64'(1));
        cyc_drive(1'b0, '0, 1'b1);
        chk("coll A valid", 64'(m_axis_tvalid), 64'(1));
        chk("coll A data", m_axis_tdata, 64'('hA));
        chk("coll A last", 64'(m_axis_tlast), 64'(1));
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            cyc_drive(1'b0, '0, 1'b1);
            if (m_axis_tvalid) begin
                found = 1;
                chk("coll B data", m_axis_tdata, 64'('hB));
                chk("coll B last", 64'(m_axis_tlast), 64'(1));
            end
        end
        chk("coll B seen", 64'(found), 64'(1));
        repeat (2) cyc_drive(1'b0, '0, 1'b1);

        // len=4: reset after two accepted beats, then a fresh packet counts from beat 1.
        cfg_pkt_len = CW'(4);
        cfg_timeout = '0;
        cyc_drive(1'b1, DW'(1), 1'b1);
        cyc_drive(1'b1, DW'(2), 1'b1);
        pulse_reset();
        set_exp(4, 'h10, 4);
        run_stream("post rst", 4, DW'('h10), 1'b0, 100);

        // len=2, 6 words: three packets counted in the statistic build only.
        pulse_reset();
        cfg_pkt_len = CW'(2);
        set_exp(6, 'h20, 2);
        run_stream("stat", 6, DW'('h20), 1'b0, 100);
`ifdef AXIS_PKTZR_STAT_EN
        exp_pkts = CW'(3);
`else
        exp_pkts = '0;
`endif
        chk("pkt_count", 64'(pkt_count), 64'(exp_pkts));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
